// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder.
//   NibW    : width of one adder slice
//   state_e : controller states (IDLE = 0, RUN = 1, DONE = 2)
package nibble_serial_adder_pkg;

  localparam int unsigned NibW = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_serial_adder_add4.sv
// 4-bit dataflow adder slice.
//   cout : carry out of bit 3
//   sum  : a + b + cin, low 4 bits
//   a, b : 4-bit operands
//   cin  : carry in
module nibble_serial_adder_add4
  import nibble_serial_adder_pkg::*;
(
  output logic            cout,
  output logic [NibW-1:0] sum,
  input  logic [NibW-1:0] a,
  input  logic [NibW-1:0] b,
  input  logic            cin
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{NibW{1'b0}}, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle wide adder. Accepts two W-bit operands plus carry-in, feeds one nibble per clock
// (LSB nibble first) through a single 4-bit slice, and presents the rebuilt sum and final carry.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   a, b, cin           : operands and carry into nibble 0
//   out_valid/out_ready : result handshake (valid only in DONE)
//   sum, cout           : A + B + cin modulo 2^W, and carry out of bit W-1
//   busy                : high in RUN or DONE
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter  int unsigned NIBBLES = 4,
  localparam int unsigned W       = NibW * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy
);

  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e state_q, state_d;

  logic [W-1:0]    a_sh_q, a_sh_d;
  logic [W-1:0]    b_sh_q, b_sh_d;
  logic            c_q, c_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;

  logic            slice_cout;
  logic [NibW-1:0] slice_sum;
  logic [W-1:0]    sum_shift;
  logic            last;

  nibble_serial_adder_add4 u_add4 (
    .cout (slice_cout),
    .sum  (slice_sum),
    .a    (a_sh_q[NibW-1:0]),
    .b    (b_sh_q[NibW-1:0]),
    .cin  (c_q)
  );

  // New nibble enters from the MSB side so that after NIBBLES shifts nibble 0 sits at the bottom.
  if (NIBBLES > 1) begin : g_shift_wide
    assign sum_shift = {slice_sum, sum_q[W-1:NibW]};
  end else begin : g_shift_single
    assign sum_shift = slice_sum;
  end

  assign last = (idx_q == IdxW'(NIBBLES - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid)  state_d = StRun;
      StRun:   if (last)      state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default:                state_d = StIdle;
    endcase
  end

  // Handshake outputs decode the state register only.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q == StRun) || (state_q == StDone);
  end

  // Datapath next-state
  always_comb begin
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    c_d    = c_q;
    idx_d  = idx_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_sh_d = a;
          b_sh_d = b;
          c_d    = cin;
          idx_d  = '0;
          sum_d  = '0;
        end
      end
      StRun: begin
        sum_d  = sum_shift;
        c_d    = slice_cout;
        a_sh_d = a_sh_q >> NibW;
        b_sh_d = b_sh_q >> NibW;
        idx_d  = idx_q + IdxW'(1);
        if (last) begin
          cout_d = slice_cout;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      c_q    <= 1'b0;
      idx_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      c_q    <= c_d;
      idx_q  <= idx_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
